// File: rtl/gpioemu_master.sv
// gpioemu_master: runs one job per command against a strobed peripheral.
// Each job writes two operands and a start word, polls status, then reads the result and the ones count.
`default_nettype none

module gpioemu_master #(
  parameter logic [15:0] ADDR_A1    = 16'h037F,
  parameter logic [15:0] ADDR_A2    = 16'h0388,
  parameter logic [15:0] ADDR_CTRL  = 16'h03A0,
  parameter logic [15:0] ADDR_W     = 16'h0390,
  parameter logic [15:0] ADDR_L     = 16'h0398,
  parameter int          STROBE_LEN = 2,
  parameter int          POLL_LIMIT = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [23:0] cmd_a1,
  input  logic [23:0] cmd_a2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_w,
  output logic [23:0] rsp_l,
  output logic        rsp_err,
  output logic [15:0] saddress,
  output logic        srd,
  output logic        swr,
  output logic [31:0] sdata_out,
  input  logic [31:0] sdata_in,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR_A1 = 3'd1,
    WR_A2 = 3'd2,
    WR_GO = 3'd3,
    POLL  = 3'd4,
    RD_W  = 3'd5,
    RD_L  = 3'd6,
    RESP  = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    PH_SETUP  = 2'd0,
    PH_STROBE = 2'd1,
    PH_HOLD   = 2'd2
  } phase_t;

  localparam logic [3:0]  STROBE_LAST = 4'(STROBE_LEN - 1);
  localparam logic [15:0] POLL_MAX    = 16'(POLL_LIMIT);

  state_t      state, state_n;
  phase_t      phase, phase_n;
  logic [3:0]  scnt, scnt_n;
  logic [15:0] poll_cnt, poll_n, poll_inc;
  logic [23:0] a1_q, a1_n, a2_q, a2_n;
  logic [31:0] rsp_w_n;
  logic [23:0] rsp_l_n;
  logic        rsp_err_n;
  logic [15:0] saddress_n;
  logic [31:0] sdata_out_n;
  logic        srd_n, swr_n;
  logic        is_rd_n, is_wr_n;

  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign poll_inc  = poll_cnt + 16'd1;

  always_comb begin
    state_n     = state;
    phase_n     = phase;
    scnt_n      = scnt;
    poll_n      = poll_cnt;
    a1_n        = a1_q;
    a2_n        = a2_q;
    rsp_w_n     = rsp_w;
    rsp_l_n     = rsp_l;
    rsp_err_n   = rsp_err;
    saddress_n  = saddress;
    sdata_out_n = sdata_out;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          a1_n    = cmd_a1;
          a2_n    = cmd_a2;
          state_n = WR_A1;
          phase_n = PH_SETUP;
          scnt_n  = 4'd0;
        end
      end
      RESP: begin
        if (rsp_ready) state_n = IDLE;
      end
      default: begin
        case (phase)
          PH_SETUP: begin
            phase_n = PH_STROBE;
            scnt_n  = 4'd0;
          end
          PH_STROBE: begin
            if (scnt == STROBE_LAST) phase_n = PH_HOLD;
            else                     scnt_n  = scnt + 4'd1;
          end
          PH_HOLD: begin
            phase_n = PH_SETUP;
            case (state)
              WR_A1: state_n = WR_A2;
              WR_A2: state_n = WR_GO;
              WR_GO: begin
                state_n = POLL;
                poll_n  = 16'd0;
              end
              POLL: begin
                poll_n = poll_inc;
                if (sdata_in[1:0] == 2'b11) begin
                  state_n = RD_W;
                end else if (poll_inc == POLL_MAX) begin
                  state_n   = RESP;
                  rsp_w_n   = 32'd0;
                  rsp_l_n   = 24'd0;
                  rsp_err_n = 1'b1;
                end
              end
              RD_W: begin
                rsp_w_n = sdata_in;
                state_n = RD_L;
              end
              RD_L: begin
                rsp_l_n   = sdata_in[23:0];
                rsp_err_n = 1'b0;
                state_n   = RESP;
              end
              default: state_n = IDLE;
            endcase
          end
          default: phase_n = PH_SETUP;
        endcase
      end
    endcase

    is_rd_n = (state_n == POLL) || (state_n == RD_W) || (state_n == RD_L);
    is_wr_n = (state_n == WR_A1) || (state_n == WR_A2) || (state_n == WR_GO);

    // Address/data only ever load on entry to a SETUP cycle, so they hold through STROBE and HOLD.
    if (phase_n == PH_SETUP && (is_rd_n || is_wr_n)) begin
      case (state_n)
        WR_A1: begin saddress_n = ADDR_A1;   sdata_out_n = {8'h00, a1_n}; end
        WR_A2: begin saddress_n = ADDR_A2;   sdata_out_n = {8'h00, a2_n}; end
        WR_GO: begin saddress_n = ADDR_CTRL; sdata_out_n = 32'h1;         end
        POLL:  begin saddress_n = ADDR_CTRL; sdata_out_n = 32'h0;         end
        RD_W:  begin saddress_n = ADDR_W;    sdata_out_n = 32'h0;         end
        RD_L:  begin saddress_n = ADDR_L;    sdata_out_n = 32'h0;         end
        default: begin
          saddress_n  = saddress;
          sdata_out_n = sdata_out;
        end
      endcase
    end

    srd_n = (phase_n == PH_STROBE) && is_rd_n;
    swr_n = (phase_n == PH_STROBE) && is_wr_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      phase     <= PH_SETUP;
      scnt      <= 4'd0;
      poll_cnt  <= 16'd0;
      a1_q      <= 24'd0;
      a2_q      <= 24'd0;
      rsp_w     <= 32'd0;
      rsp_l     <= 24'd0;
      rsp_err   <= 1'b0;
      saddress  <= 16'd0;
      sdata_out <= 32'd0;
      srd       <= 1'b0;
      swr       <= 1'b0;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      scnt      <= scnt_n;
      poll_cnt  <= poll_n;
      a1_q      <= a1_n;
      a2_q      <= a2_n;
      rsp_w     <= rsp_w_n;
      rsp_l     <= rsp_l_n;
      rsp_err   <= rsp_err_n;
      saddress  <= saddress_n;
      sdata_out <= sdata_out_n;
      srd       <= srd_n;
      swr       <= swr_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gpioemu_master.sv
// Directed bench for gpioemu_master with a small behavioural peripheral and a bus-protocol monitor.
`default_nettype none

module tb_gpioemu_master;

  localparam int SL = 2;
  localparam int PL = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        rsp_ready = 1'b0;
  logic [23:0] cmd_a1 = 24'd0;
  logic [23:0] cmd_a2 = 24'd0;
  logic [31:0] sdata_in = 32'd0;
  logic        cmd_ready, rsp_valid, rsp_err, srd, swr, busy;
  logic [31:0] rsp_w, sdata_out;
  logic [23:0] rsp_l;
  logic [15:0] saddress;

  gpioemu_master #(.STROBE_LEN(SL), .POLL_LIMIT(PL)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a1(cmd_a1), .cmd_a2(cmd_a2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_w(rsp_w), .rsp_l(rsp_l), .rsp_err(rsp_err),
    .saddress(saddress), .srd(srd), .swr(swr), .sdata_out(sdata_out), .sdata_in(sdata_in),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Peripheral: logs every access, answers status with 01 for the first ok_after polls, then 11.
  logic [48:0] log_q[$];
  int          ok_after = 0;
  int          poll_seen = 0;
  logic [31:0] model_w = 32'd0;
  logic [31:0] model_l = 32'd0;

  function automatic logic [48:0] acc(input logic wr, input logic [15:0] a, input logic [31:0] d);
    return {wr, a, d};
  endfunction

  always @(posedge srd) begin
    log_q.push_back(acc(1'b0, saddress, 32'h0));
    case (saddress)
      16'h03A0: begin
        sdata_in = (poll_seen < ok_after) ? 32'h0000_0001 : 32'h0000_0003;
        poll_seen++;
      end
      16'h0390: sdata_in = model_w;
      16'h0398: sdata_in = model_l;
      default:  sdata_in = 32'hDEAD_BEEF;
    endcase
  end

  always @(posedge swr) log_q.push_back(acc(1'b1, saddress, sdata_out));

  // Protocol monitor
  int          overlap_bad = 0;
  int          stable_bad = 0;
  int          len_bad = 0;
  int          hi_len = 0;
  logic [47:0] strobe_bus = 48'd0;

  always @(negedge clk) begin
    if (srd && swr) overlap_bad++;
    if (srd || swr) begin
      if (hi_len == 0) strobe_bus = {saddress, sdata_out};
      else if ({saddress, sdata_out} != strobe_bus) stable_bad++;
      hi_len++;
    end else begin
      if (hi_len != 0 && hi_len != SL) len_bad++;
      hi_len = 0;
    end
  end

  task automatic run_job(input logic [23:0] a1, input logic [23:0] a2, input int okn,
                         input logic [31:0] w, input logic [31:0] l, input int hold,
                         input bit pulse, output int lat, output logic [31:0] rw,
                         output logic [23:0] rl, output logic rerr);
    int unstable;
    unstable  = 0;
    log_q.delete();
    poll_seen = 0;
    ok_after  = okn;
    model_w   = w;
    model_l   = l;
    @(negedge clk);
    check("cmd_ready_idle", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1;
    cmd_a1    = a1;
    cmd_a2    = a2;
    lat       = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      cmd_valid = pulse && (lat == 10);
      rsp_ready = pulse && (lat == 12);
      if (pulse && lat == 10) check("cmd_ready_busy", {63'd0, cmd_ready}, 64'd0);
    end while (!rsp_valid && lat < 300);
    check("rsp_valid_seen", {63'd0, rsp_valid}, 64'd1);
    rw   = rsp_w;
    rl   = rsp_l;
    rerr = rsp_err;
    repeat (hold) begin
      @(negedge clk);
      if (!rsp_valid || rsp_w !== rw || rsp_l !== rl || rsp_err !== rerr) unstable++;
    end
    check("rsp_stable", 64'(unstable), 64'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_dropped", {63'd0, rsp_valid}, 64'd0);
    check("cmd_ready_after", {63'd0, cmd_ready}, 64'd1);
  endtask

  int          lat;
  logic [31:0] rw;
  logic [23:0] rl;
  logic        rerr;
  logic [48:0] exp_log[8];
  logic [48:0] got_e;
  int          nctrl, nres, vbad;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_strobes", {62'd0, srd, swr}, 64'd0);
    check("reset_bus", {16'd0, saddress, sdata_out}, 64'd0);
    check("reset_ctl", {60'd0, cmd_ready, rsp_valid, busy, rsp_err}, 64'h8);
    check("reset_rsp", {8'd0, rsp_w, rsp_l}, 64'd0);

    // Three polls, upper bits of the ones-count word must be dropped
    run_job(24'h000003, 24'h000005, 2, 32'h0000_000F, 32'hAB00_0004, 0, 1'b0, lat, rw, rl, rerr);
    check("job1_w", 64'(rw), 64'h0000_000F);
    check("job1_l", 64'(rl), 64'h000004);
    check("job1_err", 64'(rerr), 64'd0);
    check("job1_latency", 64'(lat), 64'd33);
    exp_log[0] = acc(1'b1, 16'h037F, 32'h3);
    exp_log[1] = acc(1'b1, 16'h0388, 32'h5);
    exp_log[2] = acc(1'b1, 16'h03A0, 32'h1);
    exp_log[3] = acc(1'b0, 16'h03A0, 32'h0);
    exp_log[4] = acc(1'b0, 16'h03A0, 32'h0);
    exp_log[5] = acc(1'b0, 16'h03A0, 32'h0);
    exp_log[6] = acc(1'b0, 16'h0390, 32'h0);
    exp_log[7] = acc(1'b0, 16'h0398, 32'h0);
    check("job1_log_size", 64'(log_q.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      got_e = (i < log_q.size()) ? log_q[i] : '1;
      check($sformatf("job1_access%0d", i), 64'(got_e), 64'(exp_log[i]));
    end

    // Ready on first poll: minimum latency
    run_job(24'hFFFFFF, 24'h123456, 0, 32'hCAFE_0001, 32'h0000_0018, 0, 1'b0, lat, rw, rl, rerr);
    check("job2_latency", 64'(lat), 64'd25);
    check("job2_w", 64'(rw), 64'hCAFE_0001);
    check("job2_l", 64'(rl), 64'h000018);
    got_e = (log_q.size() > 0) ? log_q[0] : '1;
    check("job2_a1_write", 64'(got_e), 64'(acc(1'b1, 16'h037F, 32'h00FF_FFFF)));

    // Stuck status: timeout after exactly POLL_LIMIT reads
    run_job(24'h000001, 24'h000002, 1000, 32'h1111_1111, 32'h0000_0022, 0, 1'b0, lat, rw, rl, rerr);
    check("job3_err", 64'(rerr), 64'd1);
    check("job3_w", 64'(rw), 64'd0);
    check("job3_l", 64'(rl), 64'd0);
    nctrl = 0;
    nres  = 0;
    foreach (log_q[i]) begin
      if (log_q[i][48] == 1'b0 && log_q[i][47:32] == 16'h03A0) nctrl++;
      if (log_q[i][47:32] == 16'h0390 || log_q[i][47:32] == 16'h0398) nres++;
    end
    check("job3_status_reads", 64'(nctrl), 64'(PL));
    check("job3_result_reads", 64'(nres), 64'd0);

    // Backpressure on the response plus a stray command and rsp_ready while busy
    run_job(24'h00000A, 24'h00000B, 0, 32'h1234_5678, 32'h0000_0007, 10, 1'b1, lat, rw, rl, rerr);
    check("job4_w", 64'(rw), 64'h1234_5678);
    check("job4_l", 64'(rl), 64'h000007);
    check("job4_log_size", 64'(log_q.size()), 64'd6);
    repeat (3) @(negedge clk);
    check("job4_idle_after", {63'd0, busy}, 64'd0);

    // Reset during the second strobe cycle of WR_A2
    log_q.delete();
    poll_seen = 0;
    ok_after  = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_a1    = 24'h000009;
    cmd_a2    = 24'h00000C;
    repeat (7) begin
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    check("abort_in_wr_a2", {47'd0, swr, saddress}, {47'd0, 1'b1, 16'h0388});
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_strobes", {62'd0, srd, swr}, 64'd0);
    check("abort_bus", {16'd0, saddress, sdata_out}, 64'd0);
    check("abort_ctl", {60'd0, cmd_ready, rsp_valid, busy, rsp_err}, 64'h8);
    check("abort_rsp", {8'd0, rsp_w, rsp_l}, 64'd0);
    vbad = 0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid || busy) vbad++;
    end
    check("abort_no_response", 64'(vbad), 64'd0);

    run_job(24'h000003, 24'h000005, 1, 32'h0000_000F, 32'h0000_0004, 0, 1'b0, lat, rw, rl, rerr);
    check("job5_latency", 64'(lat), 64'd29);
    check("job5_w", 64'(rw), 64'h0000_000F);
    check("job5_err", 64'(rerr), 64'd0);

    check("bus_overlap", 64'(overlap_bad), 64'd0);
    check("bus_stable", 64'(stable_bad), 64'd0);
    check("strobe_len", 64'(len_bad), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
